// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: FSM state encoding and default idle level shared by serial blocks
package serial_frame_tx_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;
    localparam logic DEF_IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/serial_frame_tx_piso_shifter.sv
// serial_frame_tx_piso_shifter: parallel-load shift register; out_bit is the head of the next value
module serial_frame_tx_piso_shifter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             out_bit
);
    logic [WIDTH-1:0] sr_q, sr_d;
    always_comb begin
        sr_d = load  ? data :
               shift ? (MSB_FIRST != 0 ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]}) :
                       sr_q;
    end
    assign out_bit = MSB_FIRST != 0 ? sr_d[WIDTH-1] : sr_d[0];
    always_ff @(posedge clk) begin
        sr_q <= rst ? '0 : sr_d;
    end
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: valid/ready word to serial frame transmitter with start/done markers and gap
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL,
    parameter int   GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          ser_out_q, ser_out_d, ser_valid_q, ser_valid_d;
    logic          frame_start_q, frame_start_d, frame_done_q, frame_done_d;
    logic          accept, last, shift, gap_end, out_bit;
    assign in_ready    = state_q == ST_IDLE;
    assign busy        = state_q != ST_IDLE;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    serial_frame_tx_piso_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (shift),
        .data    (in_data),
        .out_bit (out_bit)
    );
    always_comb begin
        accept    = in_valid && in_ready;
        last      = bit_cnt_q == BW'(WIDTH - 1);
        shift     = state_q == ST_SHIFT && !last;
        gap_end   = gap_cnt_q == GW'(GAP_CYCLES - 1);
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (accept) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            state_d   = last ? (GAP_CYCLES > 0 ? ST_GAP : ST_IDLE) : ST_SHIFT;
            bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
            gap_cnt_d = '0;
        end else if (state_q == ST_GAP) begin
            state_d   = gap_end ? ST_IDLE : ST_GAP;
            gap_cnt_d = gap_end ? '0 : gap_cnt_q + 1'b1;
        end
        ser_valid_d   = accept || shift;
        ser_out_d     = ser_valid_d ? out_bit : IDLE_LEVEL;
        frame_start_d = accept;
        frame_done_d  = shift && bit_cnt_q == BW'(WIDTH - 2);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            ser_out_q     <= IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed checks of both an 8-bit MSB-first and a 4-bit LSB-first transmitter
module tb_serial_frame_tx;
    typedef struct packed {
        logic       rst, vld;
        logic [7:0] data;
        logic       so, sv, fs, fd, rdy, bsy;
    } vec_t;
    logic       clk = 0, rst = 1;
    logic       a_vld = 0, b_vld = 0;
    logic [7:0] a_data = 0;
    logic [3:0] b_data = 0, sr4;
    logic       a_rdy, a_so, a_sv, a_fs, a_fd, a_bsy;
    logic       b_rdy, b_so, b_sv, b_fs, b_fd, b_bsy;
    int         errors = 0, checks = 0;
    vec_t       tbl [16];
    always #5 clk = ~clk;
    serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_vld), .in_data(a_data), .in_ready(a_rdy),
        .ser_out(a_so), .ser_valid(a_sv), .frame_start(a_fs), .frame_done(a_fd), .busy(a_bsy)
    );
    serial_frame_tx #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_vld), .in_data(b_data), .in_ready(b_rdy),
        .ser_out(b_so), .ser_valid(b_sv), .frame_start(b_fs), .frame_done(b_fd), .busy(b_bsy)
    );
    // downstream 4-bit serial-in register fed by the LSB-first transmitter
    always @(posedge clk) begin
        if (rst) sr4 <= '0;
        else if (b_sv) sr4 <= {b_so, sr4[3:1]};
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic send_a(input logic [7:0] w);
        a_vld = 1; a_data = w;
        tick();
        chk("send start", a_fs, 1); chk("send bit0", a_so, w[7]); chk("send sv0", a_sv, 1);
        a_vld = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("send bit%0d", i), a_so, w[7-i]);
            chk($sformatf("send sv%0d", i), a_sv, 1);
            chk($sformatf("send fs%0d", i), a_fs, 0);
            chk($sformatf("send fd%0d", i), a_fd, i == 7);
        end
        tick();
        chk("send gap sv", a_sv, 0); chk("send gap busy", a_bsy, 1); chk("send gap fd", a_fd, 0);
        tick();
        chk("send idle rdy", a_rdy, 1); chk("send idle busy", a_bsy, 0);
    endtask
    initial begin
        logic [7:0] w;
        logic [3:0] pb;
        for (int i = 0; i < 5; i++) tbl[i] = '{1, 0, 8'h00, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 8'hA5, 1, 1, 1, 0, 0, 1};
        tbl[7]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 8'h00, 1, 1, 0, 1, 0, 1};
        tbl[14] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; a_vld = tbl[i].vld; a_data = tbl[i].data;
            tick();
            chk($sformatf("row%0d ser_out", i), a_so, tbl[i].so);
            chk($sformatf("row%0d ser_valid", i), a_sv, tbl[i].sv);
            chk($sformatf("row%0d frame_start", i), a_fs, tbl[i].fs);
            chk($sformatf("row%0d frame_done", i), a_fd, tbl[i].fd);
            chk($sformatf("row%0d in_ready", i), a_rdy, tbl[i].rdy);
            chk($sformatf("row%0d busy", i), a_bsy, tbl[i].bsy);
        end
        a_vld = 1; a_data = 8'hFF;
        tick();
        chk("b2b first start", a_fs, 1); chk("b2b first bit", a_so, 1);
        a_data = 8'h00;
        for (int i = 1; i < 10; i++) begin
            tick();
            chk($sformatf("b2b ff sv%0d", i), a_sv, i <= 7);
            chk($sformatf("b2b ff so%0d", i), a_so, i <= 7);
            chk($sformatf("b2b ff fs%0d", i), a_fs, 0);
            chk($sformatf("b2b ff rdy%0d", i), a_rdy, i == 9);
        end
        tick();
        chk("b2b second start", a_fs, 1); chk("b2b second sv", a_sv, 1); chk("b2b second bit", a_so, 0);
        a_vld = 0;
        for (int i = 1; i < 10; i++) begin
            tick();
            chk($sformatf("b2b 00 sv%0d", i), a_sv, i <= 7);
            chk($sformatf("b2b 00 so%0d", i), a_so, 0);
        end
        w = 8'h96;
        a_vld = 1; a_data = w;
        tick();
        chk("busy start", a_fs, 1); chk("busy bit0", a_so, 1);
        for (int i = 1; i < 10; i++) begin
            a_data = ~a_data;
            tick();
            chk($sformatf("busy so%0d", i), a_so, i <= 7 ? w[7-i] : 1'b0);
            chk($sformatf("busy fs%0d", i), a_fs, 0);
            chk($sformatf("busy fd%0d", i), a_fd, i == 7);
        end
        a_vld = 0;
        tick();
        chk("busy end rdy", a_rdy, 1); chk("busy end fs", a_fs, 0); chk("busy end busy", a_bsy, 0);
        a_vld = 1; a_data = 8'hC3;
        tick();
        chk("abort bit0", a_so, 1);
        a_vld = 0;
        tick();
        chk("abort bit1", a_so, 1);
        tick();
        chk("abort bit2", a_so, 0); chk("abort bit2 sv", a_sv, 1);
        rst = 1;
        tick();
        chk("abort sv", a_sv, 0); chk("abort fd", a_fd, 0); chk("abort so", a_so, 0);
        chk("abort busy", a_bsy, 0);
        rst = 0;
        tick();
        chk("post abort sv", a_sv, 0); chk("post abort fd", a_fd, 0); chk("post abort rdy", a_rdy, 1);
        send_a(8'h3C);
        pb = 4'b1010;
        b_vld = 1; b_data = pb;
        tick();
        chk("b start", b_fs, 1); chk("b bit0", b_so, pb[0]); chk("b sv0", b_sv, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("b bit%0d", i), b_so, pb[i]);
            chk($sformatf("b fd%0d", i), b_fd, i == 3);
        end
        tick();
        chk("b end sv", b_sv, 0); chk("b end fs", b_fs, 0); chk("b end rdy", b_rdy, 1);
        chk("b downstream reg", {4'h0, sr4}, 8'h0A);
        tick();
        chk("b next accept", b_fs, 1);
        b_vld = 0;
        repeat (5) tick();
        chk("b final idle", b_bsy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
